sd_block_read_ctrl: RTL and testbench
=====================================

// Module: sd_block_read_ctrl
// PURPOSE
// Sequences single-block reads (CMD17) on the SPI SD card link once card initialization reports card_ready.
// Accepts a block-address request, shifts out the 48-bit command, collects R1, hunts the 0xFE data token,
// and streams BLOCK_BYTES data bytes to the consumer, discarding CRC16. Reports completion or a coded error.
// PARAMETERS
// R1_TIMEOUT_BYTES    8     max bytes (x8 SCLK) waited for an R1 start bit after the command
// TOKEN_TIMEOUT_BYTES 4096  max 0xFF bytes accepted before the data token
// BLOCK_BYTES         512   data bytes per block
// ADDR_SHIFT          0     CMD17 argument = req_addr << ADDR_SHIFT (0 = SDHC block addr, 9 = SDSC byte addr)
// GAP_CLOCKS          8     SCLK cycles with CS high and MOSI=1 after each transaction
// PORTS
// SCLK        in   1   SPI clock and block clock; all state updates and MISO sampling on posedge
// reset       in   1   asynchronous, active-high
// card_ready  in   1   card initialized; sampled only in IDLE
// req_valid   in   1   read request
// req_addr    in   32  block address of request
// req_ready   out  1   IDLE && card_ready
// MISO        in   1   card data out
// MOSI        out  1   card data in
// CS          out  1   card chip select, active-low
// byte_out    out  8   received data byte
// byte_valid  out  1   one-cycle pulse, byte_out valid
// byte_index  out  9   index of byte_out within block, 0..BLOCK_BYTES-1
// block_done  out  1   one-cycle pulse, transaction ended (success or error)
// err_code    out  3   0 ok,1 R1 timeout,2 R1 nonzero,3 token timeout,4 error token; held until next accept
// status_byte out  8   last R1 byte, or offending token byte when err_code=4
// BEHAVIOUR
// - Reset: state IDLE, CS=1, MOSI=1, req_ready=0 until card_ready, byte_valid=0, block_done=0, err_code=0,
//   status_byte=0xFF, byte_out=0, byte_index=0. Reset mid-transaction aborts immediately to these values.
// - Handshake: accept on posedge with req_valid && req_ready; req_addr latched; err_code cleared to 0.
// - States: IDLE -> SEND -> WAIT_R1 -> WAIT_TOKEN -> DATA -> CRC -> GAP -> IDLE; errors go WAIT_R1/WAIT_TOKEN -> GAP.
// - SEND: frame {8'h51, req_addr<<ADDR_SHIFT (32b, truncated), 8'hFF}, MSB first; CS=0, bit 47 on MOSI in the
//   cycle after the accept edge, one bit per cycle, 48 cycles.
// - WAIT_R1: MOSI=1; first sampled MISO=0 starts R1; capture that bit + next 7 as status_byte.
//   No start bit within R1_TIMEOUT_BYTES*8 samples -> err 1. R1 != 0x00 -> err 2.
// - WAIT_TOKEN: bytes framed on 8-bit boundaries from end of R1. 0xFF: keep waiting (count++);
//   0xFE: enter DATA; any other byte: err 4, status_byte=byte. Count reaching TOKEN_TIMEOUT_BYTES -> err 3.
// - DATA: 8 samples per byte, MSB first; byte_valid pulses the cycle after the 8th bit's sampling edge,
//   byte_index increments 0..BLOCK_BYTES-1, no wrap; after last byte -> CRC.
// - CRC: 16 cycles, MISO ignored, CS=0.
// - GAP: CS=1, MOSI=1 for GAP_CLOCKS cycles; block_done pulses on the GAP->IDLE edge; req_ready=1 the
//   following cycle if card_ready (no back-to-back accept during the done pulse).
// - card_ready deasserting outside IDLE is ignored; transaction completes. req_valid ignored outside IDLE.
// - Counters sized to parameters; no overflow: each terminates at its limit.
// TESTING
// - Nominal: addr 0x0000_0010, ADDR_SHIFT=0, R1=0x00 after 2 bytes, token after 3 0xFF, data i&0xFF ->
//   MOSI 0x51_00000010_FF, 512 byte_valid pulses with byte_out=i&0xFF, byte_index 0..511, block_done, err 0.
// - ADDR_SHIFT=9, addr 0x3 -> argument 0x0000_0600 on MOSI.
// - R1=0x04 -> err 2, status_byte 0x04, no byte_valid, CS high during GAP, block_done once.
// - MISO stuck 1 -> err 1 after 64 R1 samples; token byte 0x08 -> err 4, status 0x08; 4096 0xFF -> err 3.
// - Reset asserted at byte_index 100 -> CS=1, MOSI=1 immediately, no further byte_valid; new read succeeds.
// - req_valid=1 with card_ready=0 -> never accepted, CS stays 1; raising card_ready -> accepted next edge.

Source files
------------

// File: rtl/sd_block_read_ctrl.sv
// Single-block read (CMD17) sequencer for an SPI-mode SD card: sends the command, collects R1,
// hunts the 0xFE data token, streams the block bytes, skips CRC16 and reports a result code.
module sd_block_read_ctrl #(
  parameter int R1_TIMEOUT_BYTES    = 8,
  parameter int TOKEN_TIMEOUT_BYTES = 4096,
  parameter int BLOCK_BYTES         = 512,
  parameter int ADDR_SHIFT          = 0,
  parameter int GAP_CLOCKS          = 8
) (
  input  logic        SCLK,
  input  logic        reset,
  input  logic        card_ready,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        MISO,
  output logic        MOSI,
  output logic        CS,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [8:0]  byte_index,
  output logic        block_done,
  output logic [2:0]  err_code,
  output logic [7:0]  status_byte
);

  localparam int CMD_BITS   = 48;
  localparam int CRC_BITS   = 16;
  localparam int R1_SAMPLES = R1_TIMEOUT_BYTES * 8;
  localparam int IDX_W      = 9;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared phase counter serves every state; it is cleared on each state change.
  localparam int CNT_MAX = max_of(max_of(max_of(CMD_BITS, CRC_BITS),
                                         max_of(R1_SAMPLES, TOKEN_TIMEOUT_BYTES)), GAP_CLOCKS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_R1, S_WAIT_TOKEN, S_DATA, S_CRC, S_GAP
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_R1_TIMEOUT    = 3'd1,
    ERR_R1_BAD        = 3'd2,
    ERR_TOKEN_TIMEOUT = 3'd3,
    ERR_TOKEN_BAD     = 3'd4
  } err_e;

  state_e             state, state_next;
  err_e               err_q, err_next;
  logic               err_load, status_load;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   data_cnt;
  logic [2:0]         bit_cnt;
  logic [6:0]         rx_sr;
  logic [7:0]         rx_byte;
  logic [47:0]        tx_sr;
  logic [31:0]        cmd_arg;
  logic               accept, shift_en, byte_end, cnt_en;

  assign req_ready = (state == S_IDLE) && card_ready && !block_done;
  assign accept    = req_valid && req_ready;
  assign cmd_arg   = req_addr << ADDR_SHIFT;
  assign rx_byte   = {rx_sr, MISO};
  assign err_code  = err_q;

  // In WAIT_R1 bits are framed only once the start bit (first 0) has been seen.
  assign shift_en = ((state == S_WAIT_R1) && ((bit_cnt != 3'd0) || !MISO)) ||
                    (state == S_WAIT_TOKEN) || (state == S_DATA);
  assign byte_end = shift_en && (bit_cnt == 3'd7);

  assign cnt_en = (state == S_SEND) || (state == S_CRC) || (state == S_GAP) ||
                  ((state == S_WAIT_R1) && (bit_cnt == 3'd0) && MISO) ||
                  ((state == S_WAIT_TOKEN) && byte_end);

  assign CS   = !((state == S_SEND) || (state == S_WAIT_R1) || (state == S_WAIT_TOKEN) ||
                  (state == S_DATA) || (state == S_CRC));
  assign MOSI = (state == S_SEND) ? tx_sr[47] : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    err_load    = 1'b0;
    err_next    = ERR_NONE;
    status_load = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_next = S_SEND;
      S_SEND:  if (cnt == CNT_W'(CMD_BITS - 1)) state_next = S_WAIT_R1;
      S_WAIT_R1: begin
        if ((bit_cnt == 3'd0) && MISO && (cnt == CNT_W'(R1_SAMPLES - 1))) begin
          state_next = S_GAP;
          err_load   = 1'b1;
          err_next   = ERR_R1_TIMEOUT;
        end else if (byte_end) begin
          status_load = 1'b1;
          if (rx_byte == 8'h00) begin
            state_next = S_WAIT_TOKEN;
          end else begin
            state_next = S_GAP;
            err_load   = 1'b1;
            err_next   = ERR_R1_BAD;
          end
        end
      end
      S_WAIT_TOKEN: begin
        if (byte_end) begin
          if (rx_byte == 8'hFE) begin
            state_next = S_DATA;
          end else if (rx_byte != 8'hFF) begin
            state_next  = S_GAP;
            err_load    = 1'b1;
            err_next    = ERR_TOKEN_BAD;
            status_load = 1'b1;
          end else if (cnt == CNT_W'(TOKEN_TIMEOUT_BYTES - 1)) begin
            state_next = S_GAP;
            err_load   = 1'b1;
            err_next   = ERR_TOKEN_TIMEOUT;
          end
        end
      end
      S_DATA:  if (byte_end && (data_cnt == IDX_W'(BLOCK_BYTES - 1))) state_next = S_CRC;
      S_CRC:   if (cnt == CNT_W'(CRC_BITS - 1)) state_next = S_GAP;
      S_GAP:   if (cnt == CNT_W'(GAP_CLOCKS - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      data_cnt    <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      byte_index  <= '0;
      block_done  <= 1'b0;
      err_q       <= ERR_NONE;
      status_byte <= 8'hFF;
    end else begin
      byte_valid <= 1'b0;
      block_done <= (state == S_GAP) && (state_next == S_IDLE);

      if (state_next != state) cnt <= '0;
      else if (cnt_en)         cnt <= cnt + 1'b1;

      if (accept) begin
        tx_sr    <= {8'h51, cmd_arg, 8'hFF};
        err_q    <= ERR_NONE;
        bit_cnt  <= '0;
        data_cnt <= '0;
      end else if (state == S_SEND) begin
        tx_sr <= {tx_sr[46:0], 1'b1};
      end

      if (shift_en) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (status_load) status_byte <= rx_byte;
      if (err_load)    err_q       <= err_next;

      if ((state == S_DATA) && byte_end) begin
        byte_out   <= rx_byte;
        byte_valid <= 1'b1;
        byte_index <= data_cnt;
        if (data_cnt != IDX_W'(BLOCK_BYTES - 1)) data_cnt <= data_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_read_ctrl.sv
// Directed bench for sd_block_read_ctrl: a bit-level SD card model answers each command and the
// observed command frame, byte stream, cycle counts and result codes are compared to hand values.
module tb_sd_block_read_ctrl;

  logic        SCLK = 1'b0;
  logic        reset, card_ready, req_valid, MISO;
  logic [31:0] req_addr;
  logic        req_ready, MOSI, CS, byte_valid, block_done;
  logic [7:0]  byte_out, status_byte;
  logic [8:0]  byte_index;
  logic [2:0]  err_code;

  logic        req_valid9, MISO9;
  logic [31:0] req_addr9;
  logic        req_ready9, MOSI9, CS9, byte_valid9, block_done9;
  logic [7:0]  byte_out9, status_byte9;
  logic [8:0]  byte_index9;
  logic [2:0]  err_code9;

  int tests = 0;
  int fails = 0;

  always #5 SCLK = ~SCLK;

  sd_block_read_ctrl dut (
    .SCLK(SCLK), .reset(reset), .card_ready(card_ready), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .MISO(MISO), .MOSI(MOSI), .CS(CS),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_index(byte_index),
    .block_done(block_done), .err_code(err_code), .status_byte(status_byte)
  );

  sd_block_read_ctrl #(.ADDR_SHIFT(9)) dut9 (
    .SCLK(SCLK), .reset(reset), .card_ready(card_ready), .req_valid(req_valid9),
    .req_addr(req_addr9), .req_ready(req_ready9), .MISO(MISO9), .MOSI(MOSI9), .CS(CS9),
    .byte_out(byte_out9), .byte_valid(byte_valid9), .byte_index(byte_index9),
    .block_done(block_done9), .err_code(err_code9), .status_byte(status_byte9)
  );

  // Card response bits (MSB first) and results of the last transaction.
  bit          resp_q[$];
  logic [47:0] got_cmd;
  int          cmd_n, n_bv, n_done, cs_low, cs_run, cs_run_done, mosi_bad;
  logic [7:0]  rx_bytes[$];
  logic [8:0]  rx_idx[$];
  logic [2:0]  err_done, err_accept;
  logic [7:0]  stat_done;
  logic        rr_done, rr_after;
  bit          timed_out, aborted;

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) resp_q.push_back(b[i]);
  endtask

  // Issues one request, then plays the card cycle by cycle: MISO is driven on the falling edge,
  // starting the cycle after the 48th command bit; observes outputs on the same falling edge.
  task automatic run_txn(input logic [31:0] addr, input int abort_idx, input int budget);
    int cyc;
    int post;
    got_cmd = '0; cmd_n = 0; n_bv = 0; n_done = 0; cs_low = 0; cs_run = 0; cs_run_done = 0;
    mosi_bad = 0; rx_bytes.delete(); rx_idx.delete(); err_done = '0; stat_done = '0;
    rr_done = 1'b0; rr_after = 1'b0; err_accept = 3'd7; timed_out = 0; aborted = 0;
    @(negedge SCLK);
    req_addr = addr; req_valid = 1'b1;
    @(posedge SCLK); #1;
    req_valid = 1'b0; req_addr = '0;
    cyc = 0; post = -1;
    while (post != 0 && !aborted) begin
      @(negedge SCLK);
      cyc++;
      if (cyc == 1) err_accept = err_code;
      if (cmd_n == 48 && resp_q.size() > 0) MISO = resp_q.pop_front();
      else MISO = 1'b1;
      if (CS === 1'b0) begin cs_low++; cs_run = 0; end
      else cs_run++;
      if (CS === 1'b0 && cmd_n < 48) begin
        got_cmd = {got_cmd[46:0], MOSI};
        cmd_n++;
      end else if (MOSI !== 1'b1) begin
        mosi_bad++;
      end
      if (byte_valid === 1'b1) begin
        rx_bytes.push_back(byte_out);
        rx_idx.push_back(byte_index);
        n_bv++;
        if (abort_idx >= 0 && int'(byte_index) == abort_idx) aborted = 1;
      end
      if (post > 0) begin
        post--;
        if (post == 3) rr_after = req_ready;
      end
      if (block_done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          cs_run_done = cs_run; err_done = err_code; stat_done = status_byte;
          rr_done = req_ready; post = 4;
        end
      end
      if (post < 0 && cyc >= budget) begin timed_out = 1; post = 0; end
    end
    MISO = 1'b1;
  endtask

  task automatic check_common(input string name, input int exp_cs_low, input logic [2:0] exp_err);
    tests++; if (timed_out) begin fails++; $display("FAIL %s_timeout: block_done never seen", name); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL %s_done_count: got %0d want 1", name, n_done); end
    tests++; if (err_done !== exp_err) begin fails++; $display("FAIL %s_err: got %0d want %0d", name, err_done, exp_err); end
    tests++; if (cs_low != exp_cs_low) begin fails++; $display("FAIL %s_cs_low_cycles: got %0d want %0d", name, cs_low, exp_cs_low); end
    tests++; if (cs_run_done != 9) begin fails++; $display("FAIL %s_gap_cycles: got %0d want 9", name, cs_run_done); end
    tests++; if (mosi_bad != 0) begin fails++; $display("FAIL %s_mosi_idle: got %0d non-1 cycles want 0", name, mosi_bad); end
    tests++; if (rr_done !== 1'b0 || rr_after !== 1'b1) begin
      fails++; $display("FAIL %s_req_ready_after_done: got %b%b want 01", name, rr_done, rr_after); end
  endtask

  task automatic test_reset();
    reset = 1'b1; card_ready = 1'b0; req_valid = 1'b0; req_addr = '0; MISO = 1'b1;
    req_valid9 = 1'b0; req_addr9 = '0; MISO9 = 1'b1;
    repeat (3) @(negedge SCLK);
    tests++; if (CS !== 1'b1 || MOSI !== 1'b1) begin fails++; $display("FAIL reset_cs_mosi: got %b%b want 11", CS, MOSI); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    tests++; if (byte_valid !== 1'b0 || block_done !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: got %b%b want 00", byte_valid, block_done); end
    tests++; if (err_code !== 3'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_code); end
    tests++; if (status_byte !== 8'hFF) begin fails++; $display("FAIL reset_status: got %h want ff", status_byte); end
    tests++; if (byte_out !== 8'h00 || byte_index !== 9'd0) begin
      fails++; $display("FAIL reset_byte: got %h/%0d want 00/0", byte_out, byte_index); end
    reset = 1'b0;
    @(negedge SCLK);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_wo_card: got %b want 0", req_ready); end
    card_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_with_card: got %b want 1", req_ready); end
  endtask

  task automatic test_nominal();
    int bad;
    int first;
    resp_q.delete();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h00);
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFE);
    for (int i = 0; i < 512; i++) push_byte(8'(i));
    push_byte(8'hAB); push_byte(8'hCD);
    run_txn(32'h0000_0010, -1, 6000);
    tests++; if (got_cmd !== 48'h51_0000_0010_FF) begin
      fails++; $display("FAIL nominal_cmd: got %h want 51000000_10ff", got_cmd); end
    tests++; if (n_bv != 512) begin fails++; $display("FAIL nominal_byte_count: got %0d want 512", n_bv); end
    bad = 0; first = -1;
    for (int i = 0; i < rx_bytes.size(); i++) begin
      if (rx_bytes[i] !== 8'(i) || rx_idx[i] !== 9'(i)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    tests++; if (bad != 0) begin
      fails++; $display("FAIL nominal_data: %0d bad, first at %0d got %h/%0d want %h/%0d",
                        bad, first, rx_bytes[first], rx_idx[first], 8'(first), first); end
    tests++; if (stat_done !== 8'h00) begin fails++; $display("FAIL nominal_status: got %h want 00", stat_done); end
    check_common("nominal", 4216, 3'd0);
  endtask

  task automatic test_addr_shift();
    logic [47:0] cmd9;
    int n9;
    bit done9;
    cmd9 = '0; n9 = 0; done9 = 0;
    @(negedge SCLK);
    req_addr9 = 32'h3; req_valid9 = 1'b1;
    @(posedge SCLK); #1;
    req_valid9 = 1'b0;
    for (int c = 0; c < 400 && !done9; c++) begin
      @(negedge SCLK);
      if (CS9 === 1'b0 && n9 < 48) begin cmd9 = {cmd9[46:0], MOSI9}; n9++; end
      if (block_done9 === 1'b1) done9 = 1;
    end
    tests++; if (cmd9 !== 48'h51_0000_0600_FF) begin
      fails++; $display("FAIL shift9_cmd: got %h want 51000006_00ff", cmd9); end
    tests++; if (!done9 || err_code9 !== 3'd1) begin
      fails++; $display("FAIL shift9_done_err: got done=%0d err=%0d want 1/1", done9, err_code9); end
  endtask

  task automatic test_r1_error();
    resp_q.delete();
    push_byte(8'hFF); push_byte(8'h04);
    run_txn(32'h20, -1, 500);
    tests++; if (stat_done !== 8'h04) begin fails++; $display("FAIL r1bad_status: got %h want 04", stat_done); end
    tests++; if (n_bv != 0) begin fails++; $display("FAIL r1bad_byte_valid: got %0d want 0", n_bv); end
    check_common("r1bad", 64, 3'd2);
  endtask

  task automatic test_r1_timeout();
    resp_q.delete();
    run_txn(32'h30, -1, 500);
    tests++; if (err_accept !== 3'd0) begin fails++; $display("FAIL r1to_err_cleared: got %0d want 0", err_accept); end
    check_common("r1to", 112, 3'd1);
  endtask

  task automatic test_token_error();
    resp_q.delete();
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h08);
    run_txn(32'h40, -1, 500);
    tests++; if (stat_done !== 8'h08) begin fails++; $display("FAIL tokbad_status: got %h want 08", stat_done); end
    tests++; if (err_accept !== 3'd0) begin fails++; $display("FAIL tokbad_err_cleared: got %0d want 0", err_accept); end
    check_common("tokbad", 72, 3'd4);
  endtask

  task automatic test_token_timeout();
    resp_q.delete();
    push_byte(8'h00);
    run_txn(32'h50, -1, 34000);
    tests++; if (stat_done !== 8'h00) begin fails++; $display("FAIL tokto_status: got %h want 00", stat_done); end
    check_common("tokto", 32824, 3'd3);
  endtask

  task automatic test_back_to_back();
    bit seen;
    MISO = 1'b1; seen = 0;
    @(negedge SCLK);
    req_addr = 32'h60; req_valid = 1'b1;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge SCLK);
      if (block_done === 1'b1) seen = 1;
    end
    tests++; if (!seen || req_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_done_ready: got done=%0d ready=%b want 1/0", seen, req_ready); end
    @(negedge SCLK);
    tests++; if (CS !== 1'b1 || req_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_no_accept_on_done: got cs=%b ready=%b want 1/1", CS, req_ready); end
    @(negedge SCLK);
    req_valid = 1'b0;
    tests++; if (CS !== 1'b0) begin fails++; $display("FAIL b2b_accept_next: got cs=%b want 0", CS); end
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge SCLK);
      if (block_done === 1'b1) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL b2b_second_done: got 0 want 1"); end
  endtask

  task automatic test_reset_mid();
    int bv;
    int low;
    resp_q.delete();
    push_byte(8'h00); push_byte(8'hFE);
    for (int i = 0; i < 512; i++) push_byte(8'(i));
    run_txn(32'h70, 100, 6000);
    tests++; if (!aborted || n_bv != 101) begin
      fails++; $display("FAIL midrst_reach_100: got aborted=%0d bytes=%0d want 1/101", aborted, n_bv); end
    reset = 1'b1;
    #1;
    tests++; if (CS !== 1'b1 || MOSI !== 1'b1) begin
      fails++; $display("FAIL midrst_cs_mosi: got %b%b want 11", CS, MOSI); end
    tests++; if (byte_valid !== 1'b0 || byte_index !== 9'd0 || byte_out !== 8'h00) begin
      fails++; $display("FAIL midrst_outputs: got %b/%0d/%h want 0/0/00", byte_valid, byte_index, byte_out); end
    tests++; if (err_code !== 3'd0 || status_byte !== 8'hFF) begin
      fails++; $display("FAIL midrst_status: got %0d/%h want 0/ff", err_code, status_byte); end
    bv = 0; low = 0;
    repeat (3) begin
      @(negedge SCLK);
      if (byte_valid === 1'b1) bv++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge SCLK);
      if (byte_valid === 1'b1) bv++;
      if (CS === 1'b0) low++;
    end
    tests++; if (bv != 0 || low != 0) begin
      fails++; $display("FAIL midrst_quiet: got byte_valid=%0d cs_low=%0d want 0/0", bv, low); end
  endtask

  task automatic test_card_ready();
    int low;
    int rdy;
    bit seen;
    low = 0; rdy = 0; seen = 0;
    @(negedge SCLK);
    card_ready = 1'b0; req_addr = 32'h80; req_valid = 1'b1;
    repeat (10) begin
      @(negedge SCLK);
      if (CS === 1'b0) low++;
      if (req_ready !== 1'b0) rdy++;
    end
    tests++; if (low != 0 || rdy != 0) begin
      fails++; $display("FAIL notready_blocked: got cs_low=%0d ready=%0d want 0/0", low, rdy); end
    card_ready = 1'b1;
    @(posedge SCLK); #1;
    req_valid = 1'b0;
    @(negedge SCLK);
    tests++; if (CS !== 1'b0 || MOSI !== 1'b0) begin
      fails++; $display("FAIL ready_accept: got cs=%b mosi=%b want 0/0", CS, MOSI); end
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge SCLK);
      if (block_done === 1'b1) seen = 1;
    end
    tests++; if (!seen || err_code !== 3'd1) begin
      fails++; $display("FAIL ready_txn_end: got done=%0d err=%0d want 1/1", seen, err_code); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_addr_shift();
    test_r1_error();
    test_r1_timeout();
    test_token_error();
    test_token_timeout();
    test_back_to_back();
    test_reset_mid();
    test_nominal();
    test_card_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
